// File: rtl/sram_shift_reg_reader.sv
// SRAM shift register reader: waits for settled read data, pops words
// and serialises them LSB-first into a framed valid/ready chunk stream.
module sram_shift_reg_reader #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned OutWidth      = 8,
  parameter int unsigned BlockLenWidth = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     fifo_empty_i,
  input  logic [DataWidth-1:0]     fifo_front_data_i,
  input  logic                     fifo_push_i,
  output logic                     fifo_pop_o,
  input  logic [BlockLenWidth-1:0] block_len_i,
  output logic [OutWidth-1:0]      data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o
);

  localparam int unsigned NumChunks = DataWidth / OutWidth;
  localparam int unsigned IdxW =
    (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);
  localparam logic [BlockLenWidth-1:0] BlkOne = BlockLenWidth'(1);

  if (DataWidth % OutWidth != 0) begin : g_width_chk
    $error("DataWidth must be a multiple of OutWidth");
  end

  logic [NumChunks-1:0][OutWidth-1:0] word_q;
  logic                               word_valid_q;
  logic [IdxW-1:0]                    idx_q;
  logic [BlockLenWidth-1:0]           blk_cnt_q;
  logic                               rd_ok_q;

  logic hs;
  logic final_hs;
  logic load;
  logic framing_on;
  logic blk_last;

  assign hs       = word_valid_q & ready_i;
  assign final_hs = hs & (idx_q == LastIdx);
  assign load     = rd_ok_q & ~fifo_empty_i & ~fifo_push_i &
                    ~clear_i & (~word_valid_q | final_hs);

  assign framing_on = (block_len_i != '0);
  assign blk_last   = framing_on &
                      (blk_cnt_q == block_len_i - BlkOne);

  assign fifo_pop_o = load;
  assign valid_o    = word_valid_q;
  assign data_o     = word_q[idx_q];
  assign last_o     = word_valid_q & blk_last;

  // SRAM read data is stale for one cycle after any pointer move
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= ~fifo_empty_i & ~fifo_push_i &
                 ~fifo_pop_o & ~clear_i;
    end
  end

  // word capture and chunk index; flush beats load beats handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
      idx_q        <= '0;
    end else if (clear_i) begin
      word_valid_q <= 1'b0;
      idx_q        <= '0;
    end else if (load) begin
      word_q       <= fifo_front_data_i;
      word_valid_q <= 1'b1;
      idx_q        <= '0;
    end else if (hs) begin
      if (final_hs) begin
        word_valid_q <= 1'b0;
        idx_q        <= '0;
      end else begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  // block counter, wraps after the programmed last chunk
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_cnt_q <= '0;
    end else if (clear_i) begin
      blk_cnt_q <= '0;
    end else if (hs) begin
      if (blk_last || !framing_on) begin
        blk_cnt_q <= '0;
      end else begin
        blk_cnt_q <= blk_cnt_q + BlkOne;
      end
    end
  end

  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(fifo_pop_o && fifo_empty_i));

  a_no_pop_push: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(fifo_pop_o && fifo_push_i));

  a_stable_bp: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !clear_i) |=>
      ($stable(data_o) && $stable(last_o) && valid_o));

endmodule

// File: tb/tb_sram_shift_reg_reader.sv
// Directed bench for sram_shift_reg_reader with a small
// shift register model feeding it.
module tb_sram_shift_reg_reader;

  logic        clk;
  logic        rst_ni;
  logic        tb_rst_n;
  logic        clr;
  logic        push;
  logic [31:0] din;
  logic        rdy;
  logic [11:0] blen;
  logic        pop;
  logic [7:0]  data;
  logic        valid;
  logic        last;
  logic        empty;
  logic [31:0] front;

  logic [31:0] mem [16];
  logic [3:0]  rp;
  logic [3:0]  wp;
  logic [4:0]  cnt;

  int checks;
  int errors;

  logic [7:0]  cb [16];
  logic        cl [16];
  int          got_n;
  int          cyc_n;
  int          pops;
  logic [15:0] lm;
  logic [31:0] w;

  sram_shift_reg_reader dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .clear_i           (clr),
    .fifo_empty_i      (empty),
    .fifo_front_data_i (front),
    .fifo_push_i       (push),
    .fifo_pop_o        (pop),
    .block_len_i       (blen),
    .data_o            (data),
    .valid_o           (valid),
    .ready_i           (rdy),
    .last_o            (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty = (cnt == 5'd0);
  assign front = mem[rp];

  // shift register model
  always @(posedge clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 4'd1;
      end
      if (pop) rp <= rp + 4'd1;
      cnt <= cnt + {4'd0, push} - {4'd0, pop};
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [31:0] d,
                     input logic r, input logic c);
    @(posedge clk);
    #1;
    push = p;
    din  = d;
    rdy  = r;
    clr  = c;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic collect(input int n, input int maxc);
    got_n = 0;
    cyc_n = 0;
    while (got_n < n && cyc_n < maxc) begin
      idle();
      cyc_n++;
      if (valid) begin
        cb[got_n] = data;
        cl[got_n] = last;
        got_n++;
      end
    end
    chk("collect_cnt", got_n, n);
    lm = '0;
    for (int i = 0; i < got_n; i++) lm[i] = cl[i];
  endtask

  function automatic logic [31:0] wd(input int i);
    return {cb[i+3], cb[i+2], cb[i+1], cb[i]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_ni   = 1'b0;
    tb_rst_n = 1'b0;
    clr      = 1'b0;
    push     = 1'b0;
    din      = '0;
    rdy      = 1'b1;
    blen     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    rst_ni   = 1'b1;
    tb_rst_n = 1'b1;
    idle();

    // single word from empty
    w = 32'h44332211;
    cyc(1'b1, w, 1'b1, 1'b0);
    chk("t1_pop_t", pop, 0);
    idle();
    chk("t1_pop_t1", pop, 0);
    idle();
    chk("t1_pop_t2", pop, 1);
    chk("t1_valid_t2", valid, 0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t1_valid", valid, 1);
      chk("t1_data", data, w[8*i +: 8]);
      chk("t1_last", last, 0);
    end
    idle();
    chk("t1_valid_end", valid, 0);

    // backpressure with three preloaded words
    cyc(1'b1, 32'h44332211, 1'b0, 1'b0);
    cyc(1'b1, 32'h88776655, 1'b0, 1'b0);
    cyc(1'b1, 32'hccbbaa99, 1'b0, 1'b0);
    pops = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      pops += int'(pop);
      if (valid) chk("t2_hold_data", data, 8'h11);
    end
    chk("t2_pops", pops, 1);
    chk("t2_valid_held", valid, 1);
    collect(12, 40);
    chk("t2_gapless", cyc_n, 12);
    chk("t2_w0", wd(0), 32'h44332211);
    chk("t2_w1", wd(4), 32'h88776655);
    chk("t2_w2", wd(8), 32'hccbbaa99);
    idle();
    chk("t2_valid_end", valid, 0);

    // pushes while a word drains
    cyc(1'b1, 32'h04030201, 1'b1, 1'b0);
    idle();
    idle();
    chk("t3_pop_first", pop, 1);
    pops = 0;
    cyc(1'b1, 32'ha4a3a2a1, 1'b1, 1'b0);
    pops += int'(pop);
    cyc(1'b1, 32'hb4b3b2b1, 1'b1, 1'b0);
    pops += int'(pop);
    cyc(1'b1, 32'hc4c3c2c1, 1'b1, 1'b0);
    pops += int'(pop);
    cyc(1'b1, 32'hd4d3d2d1, 1'b1, 1'b0);
    pops += int'(pop);
    chk("t3_pop_in_push", pops, 0);
    idle();
    chk("t3_pop_settle", pop, 0);
    chk("t3_valid_gap", valid, 0);
    idle();
    chk("t3_pop_next", pop, 1);
    idle();
    chk("t3_valid_next", valid, 1);
    chk("t3_data_next", data, 8'ha1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    idle();
    chk("t3_flushed", valid, 0);

    // block framing, length 6
    blen = 12'd6;
    cyc(1'b1, 32'h13121110, 1'b1, 1'b0);
    cyc(1'b1, 32'h17161514, 1'b1, 1'b0);
    collect(8, 40);
    chk("t4_last8", lm[7:0], 8'h20);
    chk("t4_w0", wd(0), 32'h13121110);
    chk("t4_w1", wd(4), 32'h17161514);
    idle();
    chk("t4_idle_valid", valid, 0);
    chk("t4_idle_last", last, 0);
    cyc(1'b1, 32'h1b1a1918, 1'b1, 1'b0);
    collect(4, 20);
    chk("t4_last12", lm[3:0], 4'h8);
    chk("t4_w2", wd(0), 32'h1b1a1918);

    // clear mid-word at idx 2
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    idle();
    blen = 12'd3;
    cyc(1'b1, 32'h5d5c5b5a, 1'b1, 1'b0);
    idle();
    idle();
    idle();
    idle();
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t5_pre_valid", valid, 1);
    chk("t5_pre_data", data, 8'h5c);
    chk("t5_pre_last", last, 1);
    chk("t5_pre_pop", pop, 0);
    idle();
    chk("t5_post_valid", valid, 0);
    chk("t5_post_last", last, 0);
    cyc(1'b1, 32'h6d6c6b6a, 1'b1, 1'b0);
    collect(4, 20);
    chk("t5_restart_w", wd(0), 32'h6d6c6b6a);
    chk("t5_restart_last", lm[3:0], 4'h4);
    idle();
    blen = 12'd0;

    // async reset mid-stream
    cyc(1'b1, 32'h74737271, 1'b1, 1'b0);
    cyc(1'b1, 32'h84838281, 1'b1, 1'b0);
    idle();
    idle();
    chk("t6_pop", pop, 1);
    idle();
    chk("t6_b0", data, 8'h71);
    idle();
    chk("t6_b1", data, 8'h72);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_data", data, 0);
    chk("t6_rst_last", last, 0);
    chk("t6_rst_pop", pop, 0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    chk("t6_rel_pop0", pop, 0);
    idle();
    chk("t6_rel_pop1", pop, 1);
    idle();
    chk("t6_rel_valid", valid, 1);
    chk("t6_rel_data", data, 8'h81);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
